// File: rtl/ksa_pkg.sv
// Shared types and sizing helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int ksa_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Combinational Kogge-Stone prefix operator: (G,P) o (G',P') = (G | P&G', P&P').
module ks_prefix_cell
  import ksa_pkg::*;
(
  input  gp_t hi_i,
  input  gp_t lo_i,
  output gp_t res_o
);

  assign res_o.g = hi_i.g | (hi_i.p & lo_i.g);
  assign res_o.p = hi_i.p & lo_i.p;

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone add/subtract, LEVELS+2 cycle latency, one beat per cycle.
// A stalled output (out_valid && !out_ready) freezes every stage and drops in_ready.
module ksa_pipe
  import ksa_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int LEVELS = ksa_levels(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic stall;
  logic en;

  // Prefix position 0 is the carry-in (bit -1); position i+1 is operand bit i.
  gp_t [WIDTH:0]    gp0_d;
  gp_t [WIDTH:0]    gp_d [1:LEVELS];
  gp_t [WIDTH:0]    gp_q [0:LEVELS];
  logic [WIDTH-1:0] p_q  [0:LEVELS];
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p0_d;
  logic [LEVELS:0]  vld_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  assign stall    = out_valid_q && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  always_comb begin
    b_eff    = sub ? ~b : b;
    p0_d     = a ^ b_eff;
    gp0_d    = '0;
    gp0_d[0] = '{g: (sub | cin), p: 1'b0};
    for (int i = 0; i < WIDTH; i++) begin
      gp0_d[i+1] = '{g: (a[i] & b_eff[i]), p: p0_d[i]};
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int SPAN = 1 << (l - 1);
    for (genvar k = 0; k <= WIDTH; k++) begin : g_pos
      if (k >= SPAN) begin : g_cell
        ks_prefix_cell u_cell (
          .hi_i  (gp_q[l-1][k]),
          .lo_i  (gp_q[l-1][k-SPAN]),
          .res_o (gp_d[l][k])
        );
      end else begin : g_pass
        assign gp_d[l][k] = gp_q[l-1][k];
      end
    end
  end

  // After the last level, position i holds the carry into bit i; position WIDTH
  // still lacks the carry-in, so cout folds it in here.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i] = p_q[LEVELS][i] ^ gp_q[LEVELS][i].g;
    end
    cout_d = gp_q[LEVELS][WIDTH].g | (gp_q[LEVELS][WIDTH].p & gp_q[LEVELS][0].g);
    ovf_d  = gp_q[LEVELS][WIDTH-1].g ^ cout_d;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      gp_q[0] <= gp0_d;
      p_q[0]  <= p0_d;
      for (int l = 1; l <= LEVELS; l++) begin
        gp_q[l] <= gp_d[l];
        p_q[l]  <= p_q[l-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      vld_q       <= {vld_q[LEVELS-1:0], in_valid};
      out_valid_q <= vld_q[LEVELS];
      if (vld_q[LEVELS]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
